reg_bank_stack: RTL and testbench
=================================

// Module: reg_bank_stack
// PURPOSE
//  Parametrised register bank for the MIPS datapath: NUM_REGS x DATA_W, two combinational read
//  ports, one general write port, dedicated link (RA) write and a built-in stack-pointer unit.
//  Push/pop compute SP internally with bound checking and emit the memory address for the access.
//  Sits between decode (addresses/control) and execute/memory (operands, stack address).
// PARAMETERS
//  DATA_W    32     register width
//  NUM_REGS  64     register count; ADDR_W = $clog2(NUM_REGS)
//  RA_IDX    1      link register index
//  SP_IDX    2      stack pointer index
//  SP_RESET  111    SP value after reset (stack top, exclusive)
//  SP_MIN    0      lowest legal SP
//  SP_STEP   1      SP change per push/pop
// PORTS
//  clock     in   1       rising-edge clock
//  reset_n   in   1       async active-low reset
//  rs, rt    in   ADDR_W  read addresses
//  rd        in   ADDR_W  write address
//  wr_data   in   DATA_W  general write data
//  reg_write in   1       general write enable
//  jal       in   1       write link_data to RA_IDX
//  link_data in   DATA_W  return address
//  stack_op  in   2       00 none, 01 push, 10 pop, 11 none
//  nop       in   1       force both read ports to 0
//  err_clr   in   1       clear sp_err
//  dado1     out  DATA_W  read data (rs)
//  dado2     out  DATA_W  read data (rt)
//  sp_out    out  DATA_W  registered stack memory address
//  sp_err    out  1       sticky overflow/underflow flag
// BEHAVIOUR
//  - Reset (async, any time, aborts in-flight op): all regs 0, regs[SP_IDX]=SP_RESET, sp_out=0, sp_err=0.
//  - Reg 0 reads 0 always; writes to index 0 discarded.
//  - Writes on rising clock; reads combinational; nop=1 -> dado1=dado2=0.
//  - Push: SP<=SP-SP_STEP, sp_out<=SP-SP_STEP (pre-decrement). Pop: SP<=SP+SP_STEP, sp_out<=SP (post-increment).
//  - Overflow: push with SP-SP_STEP < SP_MIN (unsigned, incl. wrap) -> SP, sp_out unchanged, sp_err<=1.
//  - Underflow: pop with SP+SP_STEP > SP_RESET -> SP, sp_out unchanged, sp_err<=1.
//  - sp_out holds between stack ops. sp_err sticky; err_clr clears; err_clr with new error same cycle -> 1.
//  - Same-cycle priority on one register: stack_op > jal > reg_write (e.g. rd==SP_IDX with push -> push wins;
//    rd==RA_IDX with jal -> link_data wins). Non-conflicting writes all commit same cycle.
//  - Single-cycle latency for every op; no back-pressure, stack_op every cycle allowed.
// CONFIGURATION
//  BYPASS_EN defined: read ports forward this cycle's winning write value when address matches
//   (rs/rt != 0): reg_write->wr_data, jal->link_data on RA_IDX, successful push/pop->new SP on SP_IDX.
//   Failed push/pop forwards nothing. nop still forces 0.
//  BYPASS_EN undefined: reads return stored value; written value visible from the next cycle.
// STRUCTURE
//  Package reg_bank_pkg: stack_op_t enum (STK_NONE, STK_PUSH, STK_POP), ADDR_W function.
//  Sub-module reg_bank_sp_unit: next-SP arithmetic, bound checks, sp_out and sp_err registers.
//  Top: storage array, write-priority mux, read/bypass muxes.
// TESTING
//  1 reset_n=0 mid-push -> regs 0, SP=111, sp_out=0, sp_err=0 immediately, without clock edge.
//  2 reg_write rd=5 wr_data=0xDEAD, next cycle rs=5 -> dado1=0xDEAD; rd=0 write -> rs=0 reads 0.
//  3 push x3 from SP=111 -> sp_out 110,109,108, SP=108; pop x3 -> sp_out 108,109,110, SP=111.
//  4 pop at SP=111 -> sp_err=1, SP=111; push at SP=0 -> sp_err=1, SP=0; err_clr -> sp_err=0.
//  5 same cycle jal link_data=0x40, reg_write rd=1 wr_data=0x99 -> regs[1]=0x40; push + rd=2 -> SP=110.
//  6 BYPASS_EN: reg_write rd=7 0x1234, rs=7 same cycle -> dado1=0x1234; without macro -> old value; nop=1 -> 0.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the register bank / stack-pointer slice.
//   stack_op_t : encoding of the 2-bit stack_op control (2'b11 is treated as no-op)
//   addr_w()   : register-address width for a given register count
package reg_bank_pkg;

    typedef enum logic [1:0] {
        STK_NONE = 2'b00,
        STK_PUSH = 2'b01,
        STK_POP  = 2'b10
    } stack_op_t;

    // Never returns 0 so a single-register bank still has a 1-bit address.
    function automatic int unsigned addr_w(input int unsigned num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/reg_bank_sp_unit.sv
// Stack-pointer unit: next-SP arithmetic, bound checks, registered stack address and error flag.
// Ports:
//   clock, reset_n : rising-edge clock, async active-low reset
//   stack_op       : 00 none, 01 push, 10 pop, 11 none
//   err_clr        : clears the sticky error (a new error in the same cycle wins)
//   sp_cur         : current SP register contents (held in the bank)
//   sp_next        : SP value to commit when sp_wr is high
//   sp_wr          : push/pop is legal this cycle and updates SP
//   sp_out         : registered memory address of the last successful stack access
//   sp_err         : sticky overflow/underflow flag
module reg_bank_sp_unit
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SP_RESET = 111,
    parameter int unsigned SP_MIN   = 0,
    parameter int unsigned SP_STEP  = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        stack_op,
    input  logic              err_clr,
    input  logic [DATA_W-1:0] sp_cur,
    output logic [DATA_W-1:0] sp_next,
    output logic              sp_wr,
    output logic [DATA_W-1:0] sp_out,
    output logic              sp_err
);

    stack_op_t         op;
    logic              push;
    logic              pop;
    logic              ovf;
    logic              unf;
    logic [DATA_W:0]   dec_ext;
    logic [DATA_W:0]   inc_ext;
    logic [DATA_W-1:0] addr_next;

    always_comb begin
        op   = stack_op_t'(stack_op);
        push = (op == STK_PUSH);
        pop  = (op == STK_POP);

        // One extra bit: the MSB of dec_ext is the borrow (SP wrapped below zero),
        // and inc_ext cannot wrap before it is compared against the stack top.
        dec_ext = {1'b0, sp_cur} - (DATA_W+1)'(SP_STEP);
        inc_ext = {1'b0, sp_cur} + (DATA_W+1)'(SP_STEP);

        ovf = push && (dec_ext[DATA_W] || (dec_ext[DATA_W-1:0] < DATA_W'(SP_MIN)));
        unf = pop && (inc_ext > (DATA_W+1)'(SP_RESET));

        sp_wr   = (push && !ovf) || (pop && !unf);
        sp_next = push ? dec_ext[DATA_W-1:0] : inc_ext[DATA_W-1:0];
        // Push addresses the new (decremented) slot; pop addresses the old top.
        addr_next = push ? dec_ext[DATA_W-1:0] : sp_cur;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sp_out <= '0;
            sp_err <= 1'b0;
        end else begin
            if (sp_wr) begin
                sp_out <= addr_next;
            end
            if (ovf || unf) begin
                sp_err <= 1'b1;
            end else if (err_clr) begin
                sp_err <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_bank_stack.sv
// Register bank for the MIPS datapath with link-register write and built-in stack pointer.
// Ports:
//   clock, reset_n     : rising-edge clock, async active-low reset
//   rs, rt             : combinational read addresses -> dado1, dado2
//   rd, wr_data        : general write address/data, enabled by reg_write
//   jal, link_data     : writes link_data into RA_IDX
//   stack_op           : 00 none, 01 push, 10 pop, 11 none (SP lives at SP_IDX)
//   nop                : forces both read ports to zero
//   err_clr            : clears sp_err
//   sp_out             : registered stack memory address
//   sp_err             : sticky stack overflow/underflow flag
// Same-register write priority: successful stack op > jal > reg_write. Register 0 is hardwired 0.
// Build option: define BYPASS_EN to forward this cycle's winning write value onto matching read ports.
module reg_bank_stack
    import reg_bank_pkg::*;
#(
    parameter  int unsigned DATA_W   = 32,
    parameter  int unsigned NUM_REGS = 64,
    parameter  int unsigned RA_IDX   = 1,
    parameter  int unsigned SP_IDX   = 2,
    parameter  int unsigned SP_RESET = 111,
    parameter  int unsigned SP_MIN   = 0,
    parameter  int unsigned SP_STEP  = 1,
    localparam int unsigned ADDR_W   = addr_w(NUM_REGS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              reg_write,
    input  logic              jal,
    input  logic [DATA_W-1:0] link_data,
    input  logic [1:0]        stack_op,
    input  logic              nop,
    input  logic              err_clr,
    output logic [DATA_W-1:0] dado1,
    output logic [DATA_W-1:0] dado2,
    output logic [DATA_W-1:0] sp_out,
    output logic              sp_err
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] sp_next;
    logic              sp_wr;
    logic [ADDR_W-1:0] raddr [2];
    logic [DATA_W-1:0] rdata [2];

    reg_bank_sp_unit #(
        .DATA_W   (DATA_W),
        .SP_RESET (SP_RESET),
        .SP_MIN   (SP_MIN),
        .SP_STEP  (SP_STEP)
    ) u_sp_unit (
        .clock    (clock),
        .reset_n  (reset_n),
        .stack_op (stack_op),
        .err_clr  (err_clr),
        .sp_cur   (regs[SP_IDX]),
        .sp_next  (sp_next),
        .sp_wr    (sp_wr),
        .sp_out   (sp_out),
        .sp_err   (sp_err)
    );

    // A failed push/pop does not write SP, so a lower-priority write to SP_IDX may still land.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
            end
        end else begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (sp_wr && (i == SP_IDX)) begin
                    regs[i] <= sp_next;
                end else if (jal && (i == RA_IDX)) begin
                    regs[i] <= link_data;
                end else if (reg_write && (rd == ADDR_W'(i))) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        raddr[0] = rs;
        raddr[1] = rt;
        for (int unsigned p = 0; p < 2; p++) begin
            rdata[p] = regs[raddr[p]];
`ifdef BYPASS_EN
            // Forward in the same priority order the write uses; nothing forwards under reset.
            if (reset_n) begin
                if (sp_wr && (raddr[p] == ADDR_W'(SP_IDX))) begin
                    rdata[p] = sp_next;
                end else if (jal && (raddr[p] == ADDR_W'(RA_IDX))) begin
                    rdata[p] = link_data;
                end else if (reg_write && (raddr[p] == rd)) begin
                    rdata[p] = wr_data;
                end
            end
`endif
            if (nop || (raddr[p] == '0)) begin
                rdata[p] = '0;
            end
        end
    end

    assign dado1 = rdata[0];
    assign dado2 = rdata[1];

endmodule

// File: tb/tb_reg_bank_stack.sv
// Scoreboard bench for reg_bank_stack: a driver issues stimulus each cycle and queues the
// expected read data / stack outputs from a behavioural model; a monitor compares them on
// the falling clock edge.
module tb_reg_bank_stack;

    localparam int unsigned DW   = 32;
    localparam int unsigned NR   = 64;
    localparam int unsigned RA   = 1;
    localparam int unsigned SPI  = 2;
    localparam longint      SPR  = 111;
    localparam longint      SPM  = 0;
    localparam longint      STEP = 1;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [5:0]    rs, rt, rd;
    logic [DW-1:0] wr_data, link_data;
    logic          reg_write, jal, nop, err_clr;
    logic [1:0]    stack_op;
    logic [DW-1:0] dado1, dado2, sp_out;
    logic          sp_err;

    always #5 clock = ~clock;

    reg_bank_stack #(
        .DATA_W   (DW),
        .NUM_REGS (NR),
        .RA_IDX   (RA),
        .SP_IDX   (SPI),
        .SP_RESET (SPR),
        .SP_MIN   (SPM),
        .SP_STEP  (STEP)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .wr_data   (wr_data),
        .reg_write (reg_write),
        .jal       (jal),
        .link_data (link_data),
        .stack_op  (stack_op),
        .nop       (nop),
        .err_clr   (err_clr),
        .dado1     (dado1),
        .dado2     (dado2),
        .sp_out    (sp_out),
        .sp_err    (sp_err)
    );

    typedef struct {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [DW-1:0] spo;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model: architectural register file plus stack outputs.
    logic [DW-1:0] m_regs  [NR];
    logic [DW-1:0] m_spo;
    logic          m_err;
    logic [DW-1:0] nx_regs [NR];
    logic [NR-1:0] nx_wr;
    logic [DW-1:0] nx_spo;
    logic          nx_err;

    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = '0;
        m_regs[SPI] = DW'(SPR);
        m_spo = '0;
        m_err = 1'b0;
    endtask

    // Apply the writes lowest priority first so higher-priority ones overwrite.
    task automatic model_next();
        longint sp;
        logic   bad;
        sp  = longint'(m_regs[SPI]);
        bad = 1'b0;
        nx_regs = m_regs;
        nx_wr   = '0;
        nx_spo  = m_spo;
        nx_err  = m_err;
        if (reset_n) begin
            if (reg_write && rd != 0) begin
                nx_regs[rd] = wr_data;
                nx_wr[rd]   = 1'b1;
            end
            if (jal) begin
                nx_regs[RA] = link_data;
                nx_wr[RA]   = 1'b1;
            end
            if (stack_op == 2'b01) begin
                if (sp - STEP < SPM) bad = 1'b1;
                else begin
                    nx_regs[SPI] = DW'(sp - STEP);
                    nx_spo       = DW'(sp - STEP);
                    nx_wr[SPI]   = 1'b1;
                end
            end else if (stack_op == 2'b10) begin
                if (sp + STEP > SPR) bad = 1'b1;
                else begin
                    nx_regs[SPI] = DW'(sp + STEP);
                    nx_spo       = DW'(sp);
                    nx_wr[SPI]   = 1'b1;
                end
            end
            if (bad) nx_err = 1'b1;
            else if (err_clr) nx_err = 1'b0;
        end
    endtask

    task automatic model_commit();
        model_next();
        m_regs = nx_regs;
        m_spo  = nx_spo;
        m_err  = nx_err;
    endtask

    function automatic logic [DW-1:0] model_read(input logic [5:0] a);
        if (nop || a == 0) return '0;
`ifdef BYPASS_EN
        if (nx_wr[a]) return nx_regs[a];
`endif
        return m_regs[a];
    endfunction

    task automatic queue_expect();
        exp_t e;
        model_next();
        e.d1  = model_read(rs);
        e.d2  = model_read(rt);
        e.spo = m_spo;
        e.err = m_err;
        sb.push_back(e);
    endtask

    task automatic begin_cycle();
        @(posedge clock);
        if (reset_n) model_commit();
        #1;
    endtask

    task automatic drive(input logic [5:0] i_rs, input logic [5:0] i_rt, input logic [5:0] i_rd,
                         input logic [DW-1:0] i_wd, input logic i_we, input logic i_jal,
                         input logic [DW-1:0] i_ld, input logic [1:0] i_op,
                         input logic i_nop, input logic i_clr);
        begin_cycle();
        rs = i_rs; rt = i_rt; rd = i_rd; wr_data = i_wd; reg_write = i_we;
        jal = i_jal; link_data = i_ld; stack_op = i_op; nop = i_nop; err_clr = i_clr;
        queue_expect();
    endtask

    task automatic idle(input logic [5:0] i_rs, input logic [5:0] i_rt);
        drive(i_rs, i_rt, 6'd0, '0, 1'b0, 1'b0, '0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every queued expectation is compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("dado1", dado1, e.d1);
                check("dado2", dado2, e.d2);
                check("sp_out", sp_out, e.spo);
                check("sp_err", {31'd0, sp_err}, {31'd0, e.err});
            end
        end
    end

    initial begin
        logic [5:0]    r_rd;
        logic [1:0]    r_op;
        logic [DW-1:0] r_wd;

        reset_n = 1'b0;
        rs = '0; rt = '0; rd = '0; wr_data = '0; reg_write = 1'b0;
        jal = 1'b0; link_data = '0; stack_op = 2'b00; nop = 1'b0; err_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        begin_cycle();
        reset_n = 1'b1;
        rs = 6'd2;
        queue_expect();

        // General write, read-back next cycle, writes to register 0 discarded.
        drive(6'd5, 6'd0, 6'd5, 32'hDEAD, 1'b1, 1'b0, '0, 2'b00, 1'b0, 1'b0);
        drive(6'd5, 6'd0, 6'd0, 32'hBEEF, 1'b1, 1'b0, '0, 2'b00, 1'b0, 1'b0);
        idle(6'd0, 6'd5);

        // Three pushes then three pops from the reset SP.
        repeat (3) drive(6'd2, 6'd0, 6'd0, '0, 1'b0, 1'b0, '0, 2'b01, 1'b0, 1'b0);
        repeat (3) drive(6'd2, 6'd0, 6'd0, '0, 1'b0, 1'b0, '0, 2'b10, 1'b0, 1'b0);
        idle(6'd2, 6'd0);

        // Underflow at the stack top, clear, overflow at zero, error beats clear.
        drive(6'd2, 6'd0, 6'd0, '0, 1'b0, 1'b0, '0, 2'b10, 1'b0, 1'b0);
        idle(6'd2, 6'd0);
        drive(6'd2, 6'd0, 6'd0, '0, 1'b0, 1'b0, '0, 2'b00, 1'b0, 1'b1);
        drive(6'd2, 6'd0, 6'd2, 32'd0, 1'b1, 1'b0, '0, 2'b00, 1'b0, 1'b0);
        drive(6'd2, 6'd0, 6'd0, '0, 1'b0, 1'b0, '0, 2'b01, 1'b0, 1'b0);
        drive(6'd2, 6'd0, 6'd0, '0, 1'b0, 1'b0, '0, 2'b01, 1'b0, 1'b1);
        drive(6'd2, 6'd0, 6'd0, '0, 1'b0, 1'b0, '0, 2'b00, 1'b0, 1'b1);
        drive(6'd2, 6'd0, 6'd2, 32'd111, 1'b1, 1'b0, '0, 2'b00, 1'b0, 1'b0);

        // Write-priority conflicts: jal over reg_write on RA, push over reg_write on SP.
        drive(6'd1, 6'd2, 6'd1, 32'h99, 1'b1, 1'b1, 32'h40, 2'b00, 1'b0, 1'b0);
        drive(6'd1, 6'd2, 6'd2, 32'h55, 1'b1, 1'b0, '0, 2'b01, 1'b0, 1'b0);
        idle(6'd1, 6'd2);

        // Same-cycle read of a register being written, then nop forcing zero.
        drive(6'd7, 6'd1, 6'd7, 32'h1234, 1'b1, 1'b0, '0, 2'b00, 1'b0, 1'b0);
        idle(6'd7, 6'd0);
        drive(6'd7, 6'd2, 6'd0, '0, 1'b0, 1'b0, '0, 2'b00, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a push cycle.
        drive(6'd2, 6'd5, 6'd0, '0, 1'b0, 1'b0, '0, 2'b01, 1'b0, 1'b0);
        drive(6'd2, 6'd5, 6'd0, '0, 1'b0, 1'b0, '0, 2'b01, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        model_reset();
        void'(sb.pop_back());
        queue_expect();
        begin_cycle();
        queue_expect();
        begin_cycle();
        reset_n = 1'b1;
        stack_op = 2'b00;
        queue_expect();
        idle(6'd2, 6'd5);

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            r_op = 2'($urandom_range(0, 3));
            r_rd = 6'($urandom_range(0, 15));
            if (r_rd == 6'(SPI) && (r_op == 2'b01 || r_op == 2'b10)) r_rd = 6'd3;
            r_wd = (r_rd == 6'(SPI)) ? DW'($urandom_range(0, 111)) : DW'($urandom);
            drive(($urandom_range(0, 3) == 0) ? 6'd2 : 6'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0) ? 6'd1 : 6'($urandom_range(0, 63)),
                  r_rd, r_wd, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                  DW'($urandom), r_op, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end
        idle(6'd2, 6'd1);

        repeat (3) @(negedge clock);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
